// File: rtl/cpu_cache_ctrl.sv
// Direct-mapped write-back cache controller: tag/valid/dirty bookkeeping, CPU hold-off,
// and spill/fill burst sequencing against the sdramburst host port.
module cpu_cache_ctrl #(
  parameter int INDEX_BITS = 5,
  parameter int TAG_BITS   = 15
) (
  input  logic                  clk1x,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic [23:0]           cpu_addr,
  input  logic                  cpu_write,
  output logic                  cpu_ack,
  output logic                  sd_rd,
  output logic                  sd_wr,
  output logic [23:0]           sd_addr,
  input  logic                  sd_ready,
  input  logic [2:0]            sd_burst_offset,
  output logic [INDEX_BITS-1:0] ram_line,
  output logic [2:0]            ram_offset,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic                  busy
);

  localparam int LINES = 2 ** INDEX_BITS;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    SPILL_REQ,
    SPILL_WAIT,
    FILL_REQ,
    FILL_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [LINES-1:0]    valid;
  logic [LINES-1:0]    dirty;
  logic [TAG_BITS-1:0] tag_mem [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic                  last_beat;

  assign idx       = cpu_addr[4 +: INDEX_BITS];
  assign tag       = cpu_addr[23 -: TAG_BITS];
  assign hit       = valid[idx] && (tag_mem[idx] == tag);
  assign last_beat = sd_ready && (sd_burst_offset == 3'd7);
  assign busy      = (state != IDLE);

  // Byte offset within the line is not needed by the controller.
  logic unused_byte_offset;
  assign unused_byte_offset = ^cpu_addr[3:0];

  always_ff @(posedge clk1x) begin
    if (reset) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE:       if (cpu_req && hit && cpu_write) dirty[idx] <= 1'b1;
        SPILL_WAIT: if (last_beat) dirty[idx] <= 1'b0;
        FILL_WAIT: begin
          if (last_beat) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk1x) begin
    if (!reset && state == FILL_WAIT && last_beat)
      tag_mem[idx] <= tag;
  end

  always_comb begin
    state_nxt  = state;
    cpu_ack    = 1'b0;
    sd_rd      = 1'b0;
    sd_wr      = 1'b0;
    sd_addr    = '0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_line   = idx;
    ram_offset = '0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (hit)                          state_nxt = ACK;
          else if (valid[idx] && dirty[idx]) state_nxt = SPILL_REQ;
          else                              state_nxt = FILL_REQ;
        end
      end
      ACK: begin
        cpu_ack   = 1'b1;
        state_nxt = IDLE;
      end
      SPILL_REQ: begin
        sd_wr     = 1'b1;
        sd_addr   = {tag_mem[idx], idx, 4'b0000};
        state_nxt = SPILL_WAIT;
      end
      SPILL_WAIT: begin
        ram_en     = 1'b1;
        ram_offset = sd_burst_offset;
        if (last_beat) state_nxt = FILL_REQ;
      end
      FILL_REQ: begin
        sd_rd     = 1'b1;
        sd_addr   = {cpu_addr[23:4], 4'b0000};
        state_nxt = FILL_WAIT;
      end
      FILL_WAIT: begin
        ram_en     = sd_ready;
        ram_we     = sd_ready;
        ram_offset = sd_burst_offset;
        if (last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_cache_ctrl.sv
// Directed self-checking bench for cpu_cache_ctrl: hit/miss, spill+fill, gapped fill, reset mid-burst.
module tb_cpu_cache_ctrl;

  logic        clk1x = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [23:0] cpu_addr;
  logic        cpu_write;
  logic        cpu_ack;
  logic        sd_rd;
  logic        sd_wr;
  logic [23:0] sd_addr;
  logic        sd_ready;
  logic [2:0]  sd_burst_offset;
  logic [4:0]  ram_line;
  logic [2:0]  ram_offset;
  logic        ram_en;
  logic        ram_we;
  logic        busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk1x = ~clk1x;

  cpu_cache_ctrl #(.INDEX_BITS(5), .TAG_BITS(15)) dut (
    .clk1x(clk1x), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_write(cpu_write), .cpu_ack(cpu_ack),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_addr(sd_addr),
    .sd_ready(sd_ready), .sd_burst_offset(sd_burst_offset),
    .ram_line(ram_line), .ram_offset(ram_offset), .ram_en(ram_en), .ram_we(ram_we),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk1x);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", name, obs, exp);
    end
  endtask

  // {cpu_ack, sd_rd, sd_wr, ram_en, ram_we, busy}
  function automatic logic [5:0] ctl();
    return {cpu_ack, sd_rd, sd_wr, ram_en, ram_we, busy};
  endfunction

  // Eight beats; optional gap of idle cycles between beats 3 and 4 (fill only).
  task automatic burst(input string name, input logic we_exp, input logic [4:0] line_exp,
                       input int unsigned gap);
    for (int unsigned b = 0; b < 8; b++) begin
      if (b == 4) begin
        for (int unsigned g = 0; g < gap; g++) begin
          sd_ready = 1'b0;
          sd_burst_offset = 3'd5;
          #1;
          chk({name, "_gap"}, {30'd0, ram_en, ram_we}, 32'd0);
          chk({name, "_gap_busy"}, {31'd0, busy}, 32'd1);
          tick();
        end
      end
      sd_ready = 1'b1;
      sd_burst_offset = b[2:0];
      #1;
      chk({name, "_beat"}, {22'd0, sd_rd, sd_wr, ram_en, ram_we, line_exp == ram_line, ram_offset},
          {22'd0, 1'b0, 1'b0, 1'b1, we_exp, 1'b1, b[2:0]});
      tick();
    end
    sd_ready = 1'b0;
    sd_burst_offset = 3'd0;
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_write = 1'b0;
    sd_ready = 1'b0; sd_burst_offset = 3'd0;
    tick(); tick();
    chk("reset_ctl", {26'd0, ctl()}, 32'd0);
    chk("reset_addr", {5'd0, sd_addr, ram_offset}, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_ctl", {26'd0, ctl()}, 32'd0);

    // Cold read miss at 0x000130
    cpu_req = 1'b1; cpu_addr = 24'h000130; cpu_write = 1'b0;
    tick();
    chk("miss1_rdreq", {26'd0, ctl()}, {26'd0, 6'b010001});
    chk("miss1_addr", {8'd0, sd_addr}, 32'h000130);
    tick();
    burst("miss1_fill", 1'b1, 5'h13, 0);
    chk("miss1_m1", {26'd0, ctl()}, 32'd0);
    tick();
    chk("miss1_ack", {26'd0, ctl()}, {26'd0, 6'b100001});
    cpu_req = 1'b0;
    tick();
    chk("miss1_after", {26'd0, ctl()}, 32'd0);

    // Repeat read: hit, ack next cycle
    cpu_req = 1'b1;
    tick();
    chk("hit_ack", {26'd0, ctl()}, {26'd0, 6'b100001});
    cpu_req = 1'b0;
    tick();
    chk("hit_after", {26'd0, ctl()}, 32'd0);

    // Write hit at 0x000134 makes the line dirty
    cpu_req = 1'b1; cpu_addr = 24'h000134; cpu_write = 1'b1;
    tick();
    chk("whit_ack", {26'd0, ctl()}, {26'd0, 6'b100001});
    cpu_req = 1'b0; cpu_write = 1'b0;
    tick();

    // Aliasing read 0x010130: spill old line, then fill
    cpu_req = 1'b1; cpu_addr = 24'h010130;
    tick();
    chk("dirty_wrreq", {26'd0, ctl()}, {26'd0, 6'b001001});
    chk("dirty_spill_addr", {8'd0, sd_addr}, 32'h000130);
    tick();
    burst("spill", 1'b0, 5'h13, 0);
    chk("dirty_rdreq", {26'd0, ctl()}, {26'd0, 6'b010001});
    chk("dirty_fill_addr", {8'd0, sd_addr}, 32'h010130);
    tick();
    burst("dirty_fill", 1'b1, 5'h13, 0);
    chk("dirty_m1", {26'd0, ctl()}, 32'd0);
    tick();
    chk("dirty_ack", {26'd0, ctl()}, {26'd0, 6'b100001});
    cpu_req = 1'b0;
    tick();

    // Clean miss at 0x000200 with a 5-cycle gap in the fill
    cpu_req = 1'b1; cpu_addr = 24'h000200;
    tick();
    chk("clean_rdreq", {26'd0, ctl()}, {26'd0, 6'b010001});
    chk("clean_addr", {8'd0, sd_addr}, 32'h000200);
    tick();
    burst("gap_fill", 1'b1, 5'h00, 5);
    chk("gap_m1", {26'd0, ctl()}, 32'd0);
    tick();
    chk("gap_ack", {26'd0, ctl()}, {26'd0, 6'b100001});
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1;
    tick();
    chk("gap_rehit", {26'd0, ctl()}, {26'd0, 6'b100001});
    cpu_req = 1'b0;
    tick();

    // Reset asserted during beat 4 of a fill at 0x000440
    cpu_req = 1'b1; cpu_addr = 24'h000440;
    tick();
    chk("rst_rdreq", {26'd0, ctl()}, {26'd0, 6'b010001});
    tick();
    for (int unsigned b = 0; b < 4; b++) begin
      sd_ready = 1'b1; sd_burst_offset = b[2:0];
      tick();
    end
    sd_ready = 1'b1; sd_burst_offset = 3'd4; reset = 1'b1;
    tick();
    sd_ready = 1'b0; sd_burst_offset = 3'd0;
    chk("rst_mid_ctl", {26'd0, ctl()}, 32'd0);
    chk("rst_mid_addr", {8'd0, sd_addr}, 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_remiss", {26'd0, ctl()}, {26'd0, 6'b010001});
    chk("rst_remiss_addr", {8'd0, sd_addr}, 32'h000440);
    tick();
    burst("rst_fill", 1'b1, 5'h04, 0);
    tick();
    chk("rst_ack", {26'd0, ctl()}, {26'd0, 6'b100001});
    cpu_req = 1'b0;
    tick();

    // Reset also dropped the line at index 0x13: plain fill, no spill
    cpu_req = 1'b1; cpu_addr = 24'h010130;
    tick();
    chk("post_rst_nospill", {26'd0, ctl()}, {26'd0, 6'b010001});
    cpu_req = 1'b0;
    tick();
    burst("post_rst_fill", 1'b1, 5'h13, 0);
    tick();
    chk("drop_req_noack", {26'd0, ctl()}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_cache_ctrl.md
# cpu_cache_ctrl

Direct-mapped, write-back cache controller between the 6502-side CPU bus and the `sdramburst` host port. It holds the tag, valid and dirty state for a 32-line × 16-byte cache. It decides hit or miss for each cacheable CPU access and holds off the CPU phase advance until the access can complete. On a miss it sequences a spill burst (dirty victim) and then a fill burst to SDRAM, driving port B of the cache data RAM in step with the SDRAM burst beats.

## Interface
Parameters:
- `INDEX_BITS`, 5: line index width; the cache has 2^INDEX_BITS lines.
- `TAG_BITS`, 15: tag width, taken from `cpu_addr[23:9]`.

Ports:
- `clk1x`  in  1  system clock; also clocks port B of the cache data RAM.
- `reset`  in  1  synchronous, active-high.
- `cpu_req`  in  1  cacheable CPU access pending in PHI1; held high until `cpu_ack`.
- `cpu_addr`  in  24  CPU byte address; stable while `cpu_req` is high.
- `cpu_write`  in  1  1 = write access, 0 = read access.
- `cpu_ack`  out  1  one-cycle pulse; the access hit and the CPU may advance its phase.
- `sd_rd`  out  1  SDRAM burst-read request, one-cycle pulse.
- `sd_wr`  out  1  SDRAM burst-write request, one-cycle pulse.
- `sd_addr`  out  24  SDRAM burst address, 16-byte aligned.
- `sd_ready`  in  1  burst beat valid, from `sdramburst`.
- `sd_burst_offset`  in  3  beat index 0..7 within the burst.
- `ram_line`  out  5  port-B line select (index field).
- `ram_offset`  out  3  port-B 16-bit word select.
- `ram_en`  out  1  port-B enable.
- `ram_we`  out  1  port-B write enable.
- `busy`  out  1  high in any state other than IDLE.

## Operation
Address split:
- tag = `cpu_addr[23:9]`
- index = `cpu_addr[8:4]`
- byte offset = `cpu_addr[3:0]`

Per-line state: `valid`, `dirty`, `tag`. All valid and dirty bits clear on reset; the tag array is not reset.

Hit condition: `valid[index] && tag[index] == cpu_addr[23:9]`.

States:
- **IDLE**
  - If `cpu_req` is low, stay in IDLE.
  - On a hit, go to ACK. If `cpu_write`, set `dirty[index]`.
  - On a miss where `valid[index] && dirty[index]`, go to SPILL_REQ.
  - On any other miss, go to FILL_REQ.
- **ACK**
  - `cpu_ack` = 1 for exactly this cycle.
  - `cpu_req` is ignored in this cycle.
  - Next state is IDLE.
- **SPILL_REQ**
  - `sd_wr` = 1.
  - `sd_addr` = {`tag[index]`, index, 4'b0000}.
  - Next state is SPILL_WAIT.
- **SPILL_WAIT**
  - `ram_en` = 1, `ram_we` = 0.
  - `ram_line` = index, `ram_offset` = `sd_burst_offset`.
  - On `sd_ready && sd_burst_offset == 7`: clear `dirty[index]` and go to FILL_REQ.
- **FILL_REQ**
  - `sd_rd` = 1.
  - `sd_addr` = {`cpu_addr[23:4]`, 4'b0000}.
  - Next state is FILL_WAIT.
- **FILL_WAIT**
  - `ram_en` = `ram_we` = `sd_ready`.
  - `ram_line` = index, `ram_offset` = `sd_burst_offset`.
  - On `sd_ready && sd_burst_offset == 7`: `valid[index]` = 1, `dirty[index]` = 0, `tag[index]` = `cpu_addr[23:9]`, then go to IDLE.
  - The re-lookup in IDLE then hits.

Rules:
- Outside SPILL_WAIT and FILL_WAIT: `ram_en` = `ram_we` = 0, and `ram_line` = index.
- `sd_rd` and `sd_wr` are never high in the same cycle.
- Each is high for exactly one cycle per burst.

## Timing
- Reset values:
  - `cpu_ack`, `sd_rd`, `sd_wr`, `ram_en`, `ram_we`, `busy` = 0.
  - `sd_addr` = 0, `ram_offset` = 0.
  - State is IDLE.
- Hit latency: `cpu_req` sampled high in IDLE at cycle N gives `cpu_ack` high at N+1.
- Clean miss:
  - `sd_rd` at N+1.
  - Fill beats arrive from N+2 onward.
  - The last beat at cycle M returns the controller to IDLE at M+1.
  - `cpu_ack` at M+2.
- Dirty miss: a spill of the same shape as the fill runs first; FILL_REQ follows in the cycle after the last spill beat.
- Beats with `sd_ready` = 0 are ignored. There is no timeout.
- `cpu_req` dropping mid-burst:
  - The burst runs to completion and the line is installed.
  - IDLE then sees `cpu_req` = 0 and no ack is issued.
- `cpu_addr` must be stable from request until ack; otherwise behaviour is undefined.
- Reset during a burst:
  - Returns to IDLE immediately and clears all valid and dirty bits.
  - The partial `sdramburst` transfer is abandoned.
- Index wrap-around: addresses differing only in the tag alias to the same line; the resident line is evicted.

## Test plan
- After reset, read at 0x000130 → miss:
  - `sd_rd` pulse with `sd_addr` = 0x000130.
  - 8 fill beats with `ram_we` = 1 and `ram_line` = 0x13, offsets 0..7.
  - `cpu_ack` 2 cycles after the last beat.
- Repeat the read of 0x000130 → `cpu_ack` exactly 1 cycle after `cpu_req`; no `sd_rd`.
- Write hit at 0x000134, then read 0x010130 (same index 0x13, new tag):
  - First, `sd_wr` with `sd_addr` = 0x000130 and 8 beats with `ram_en` = 1, `ram_we` = 0.
  - Then `sd_rd` with `sd_addr` = 0x010130.
  - Then `cpu_ack`.
- Read 0x000200 with no prior dirty line (clean miss) → no `sd_wr` is issued; only `sd_rd`.
- Fill with gaps where `sd_ready` is low between beats 3 and 4 for 5 cycles → no RAM write in the gap; the line is still installed after beat 7.
- Assert `reset` during beat 4 of a fill → next cycle all outputs are 0 and `busy` = 0; a subsequent read of the same address misses again.
